// File: rtl/branch_lut_loader_pkg.sv
// Shared constants, loader state encoding and HI-byte field layout for the
// branch-target table loader.
package branch_lut_pkg;

  localparam int AW    = 5;
  localparam int DW    = 10;
  localparam int DEPTH = 32;

  // HI byte = {idx[AW-1:0], reserved, tgt[DW-1:8]}
  localparam int HI_TGT_W   = DW - 8;
  localparam int HI_RSV_BIT = HI_TGT_W;
  localparam int HI_IDX_LSB = HI_TGT_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNT  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    FIN  = 3'd4
  } loader_state_t;

  // A COUNT byte is legal when its top two bits are clear and N fits the table.
  function automatic logic count_ok(input logic [7:0] b);
    return (b[7:6] == 2'b00) && (int'(b[5:0]) <= DEPTH);
  endfunction

endpackage

// File: rtl/branch_lut_loader_if.sv
// Byte-stream load port of the branch-target table loader.
// A byte moves on a rising edge where InValid and InReady are both 1; the
// source holds InByte stable while InValid is high and InReady is low, and
// InReady never depends combinationally on InValid.
interface branch_lut_loader_if;
  logic       LoadStart;
  logic       InValid;
  logic [7:0] InByte;
  logic       InReady;

  modport master (
    output LoadStart,
    output InValid,
    output InByte,
    input  InReady
  );

  modport slave (
    input  LoadStart,
    input  InValid,
    input  InByte,
    output InReady
  );
endinterface

// File: rtl/branch_lut_loader_target_table.sv
// DEPTH x DW branch-target storage: one synchronous write port, one
// combinational read port, asynchronous clear of every entry.
module target_table
  import branch_lut_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-cycle read of the written index sees the old value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_lut_loader.sv
// Run-time loader for the branch-target table: parses {COUNT, N x {HI, LO}}
// byte records into table writes and serves the fetch-side combinational read.
module branch_lut_loader
  import branch_lut_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  branch_lut_loader_if.slave   ld,
  input  logic [AW-1:0]        addr,
  output logic [DW-1:0]        Target,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output loader_state_t        dbg_state
);

  loader_state_t         state_q;
  logic [5:0]            rem_q;
  logic [AW-1:0]         idx_q;
  logic [HI_TGT_W-1:0]   tgt_hi_q;
  logic                  in_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic                  xfer;
  logic                  tbl_we;
  logic [DW-1:0]         tbl_wdata;

  assign xfer      = ld.InValid & in_ready_q;
  assign tbl_we    = xfer && (state_q == LO);
  assign tbl_wdata = {tgt_hi_q, ld.InByte};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      tgt_hi_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld.LoadStart) begin
            state_q    <= CNT;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        CNT: begin
          if (xfer) begin
            if (!count_ok(ld.InByte)) begin
              state_q    <= IDLE;
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else if (ld.InByte[5:0] == 6'd0) begin
              state_q    <= FIN;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              rem_q   <= ld.InByte[5:0];
              state_q <= HI;
            end
          end
        end
        HI: begin
          if (xfer) begin
            // A set reserved bit aborts the session before this entry is written.
            if (ld.InByte[HI_RSV_BIT]) begin
              state_q    <= IDLE;
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              idx_q    <= ld.InByte[HI_IDX_LSB +: AW];
              tgt_hi_q <= ld.InByte[HI_TGT_W-1:0];
              state_q  <= LO;
            end
          end
        end
        LO: begin
          if (xfer) begin
            if (rem_q == 6'd1) begin
              state_q    <= FIN;
              done_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              rem_q   <= rem_q - 6'd1;
              state_q <= HI;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  target_table u_table (
    .clk_i   (Clk),
    .rst_n_i (Reset_n),
    .we_i    (tbl_we),
    .waddr_i (idx_q),
    .wdata_i (tbl_wdata),
    .raddr_i (addr),
    .rdata_o (Target)
  );

  assign ld.InReady = in_ready_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_branch_lut_loader.sv
// Self-checking bench for branch_lut_loader: drives byte-stream load sessions
// and compares table contents and status outputs against a reference table.
module tb_branch_lut_loader;
  import branch_lut_pkg::*;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] Target;
  logic          Busy;
  logic          Done;
  logic          Err;
  loader_state_t dbg_state;

  branch_lut_loader_if ld ();

  branch_lut_loader dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ld        (ld),
    .addr      (addr),
    .Target    (Target),
    .Busy      (Busy),
    .Done      (Done),
    .Err       (Err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_load();
    ld.LoadStart = 1'b1;
    tick();
    ld.LoadStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall = 0);
    repeat (stall) tick();
    ld.InValid = 1'b1;
    ld.InByte  = b;
    for (int k = 0; k < 50 && !ld.InReady; k++) tick();
    if (!ld.InReady) begin
      check("ready_timeout", 32'd0, 32'd1);
      ld.InValid = 1'b0;
      return;
    end
    tick();
    ld.InValid = 1'b0;
    ld.InByte  = 8'($urandom_range(0, 255));
  endtask

  task automatic send_rec(input logic [AW-1:0] idx, input logic [DW-1:0] tgt, input int stall = 0);
    send_byte({idx, 1'b0, tgt[DW-1:8]}, stall);
    addr = idx;
    #1;
    check("same_cycle_old", 32'(Target), 32'(model[idx]));
    exp_q.push_back(tgt);
    model[idx] = tgt;
    send_byte(tgt[7:0], stall);
    #1;
    check("write_visible", 32'(Target), 32'(exp_q.pop_front()));
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(model[i]);
    for (int i = 0; i < DEPTH; i++) begin
      addr = AW'(i);
      #1;
      check(tag, 32'(Target), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_done_pulse(input string tag);
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_err"}, 32'(Err), 32'd0);
    tick();
    check({tag, "_done_gone"}, 32'(Done), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [DW-1:0] t;
    ld.LoadStart = 1'b0;
    ld.InValid   = 1'b0;
    ld.InByte    = 8'h00;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    // Reset state
    repeat (2) tick();
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ready", 32'(ld.InReady), 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    sweep("rst_tbl");
    Reset_n = 1'b1;
    tick();

    // Basic two-record load
    start_load();
    check("t2_busy", 32'(Busy), 32'd1);
    check("t2_ready", 32'(ld.InReady), 32'd1);
    send_byte(8'h02);
    send_rec(5'd0, 10'h016);
    send_rec(5'd1, 10'h14F);
    check_done_pulse("t2");
    sweep("t2_tbl");

    // Empty session
    start_load();
    send_byte(8'h00);
    check_done_pulse("t3");

    // COUNT out of range, then recovery
    start_load();
    send_byte(8'h21);
    check("t4_err", 32'(Err), 32'd1);
    check("t4_busy", 32'(Busy), 32'd0);
    check("t4_nodone", 32'(Done), 32'd0);
    tick();
    check("t4_nodone2", 32'(Done), 32'd0);
    start_load();
    check("t4_err_clr", 32'(Err), 32'd0);
    send_byte(8'h40);
    check("t4_topbits_err", 32'(Err), 32'd1);
    check("t4_topbits_state", 32'(dbg_state), 32'(IDLE));

    // LoadStart mid-session is ignored
    start_load();
    send_byte(8'h01);
    start_load();
    check("busy_restart_state", 32'(dbg_state), 32'(HI));
    check("busy_restart_err", 32'(Err), 32'd0);
    send_rec(5'd7, 10'h3C5);
    check_done_pulse("restart");

    // Reserved bit in the second HI byte
    start_load();
    send_byte(8'h02);
    send_rec(5'd5, 10'h2AB);
    send_byte(8'h04);
    check("t5_err", 32'(Err), 32'd1);
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_nodone", 32'(Done), 32'd0);
    sweep("t5_tbl");

    // Reset between HI and LO
    start_load();
    send_byte(8'h01);
    send_byte({5'd10, 1'b0, 2'b11});
    Reset_n = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    check("t6_state", 32'(dbg_state), 32'(IDLE));
    check("t6_busy", 32'(Busy), 32'd0);
    check("t6_ready", 32'(ld.InReady), 32'd0);
    sweep("t6_tbl");
    tick();
    Reset_n = 1'b1;
    tick();

    // Stalled load with duplicate index (last write wins)
    start_load();
    send_byte(8'h03, 5);
    send_rec(5'd3, 10'h155, 5);
    send_rec(5'd9, 10'h0F0, 5);
    send_rec(5'd3, 10'h2AA, 5);
    check_done_pulse("stall");
    sweep("stall_tbl");

    // Full-depth session (N == DEPTH)
    start_load();
    send_byte(8'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      t = DW'($urandom_range(0, (1 << DW) - 1));
      send_rec(AW'(i), t, $urandom_range(0, 2));
    end
    check_done_pulse("full");
    sweep("full_tbl");

    // Random short sessions
    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 6);
      start_load();
      send_byte(8'(n), $urandom_range(0, 3));
      for (int r = 0; r < n; r++) begin
        t = DW'($urandom_range(0, (1 << DW) - 1));
        send_rec(AW'($urandom_range(0, DEPTH - 1)), t, $urandom_range(0, 3));
      end
      check_done_pulse("rand");
    end
    sweep("rand_tbl");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
